// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: gates uart_rx, buffers bytes in a show-ahead FIFO, flags break/overrun.
// Optional inter-byte idle timeout is built when UART_RX_CTRL_TIMEOUT_EN is defined.
module uart_rx_ctrl #(
  parameter int PAYLOAD_BITS   = 8,
  parameter int FIFO_DEPTH     = 8,
  parameter int HOLDOFF_CYCLES = 1024,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        ctrl_enable,
  input  logic                        ctrl_flush,
  output logic                        rx_en,
  input  logic                        rx_valid,
  input  logic                        rx_break,
  input  logic [PAYLOAD_BITS-1:0]     rx_data,
  output logic [PAYLOAD_BITS-1:0]     m_data,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overrun,
  output logic                        break_det,
  output logic                        timeout
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int HW = $clog2(HOLDOFF_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    ACTIVE,
    HOLDOFF
  } state_e;

  state_e state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic rx_en_q, rx_en_d;
  logic brk_q, brk_d;
  logic to_q, to_d;

  logic [PAYLOAD_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [LW-1:0] level_q, level_d;
  logic ovr_q, ovr_d;
  logic mval_q;

  logic live, byte_req, brk_req;
  logic full, push, pop;

  assign live     = (state_q == ARMED) || (state_q == ACTIVE);
  assign byte_req = live & rx_valid & ~rx_break;
  assign brk_req  = live & rx_valid & rx_break;

`ifdef UART_RX_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt_q, tcnt_d;
`else
  logic unused_timeout_param;
  assign unused_timeout_param = |TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    to_d    = 1'b0;
`ifdef UART_RX_CTRL_TIMEOUT_EN
    tcnt_d  = tcnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (ctrl_enable) state_d = ARMED;
      end
      ARMED, ACTIVE: begin
        if (brk_req) begin
          state_d = HOLDOFF;
          hold_d  = '0;
        end else if (byte_req) begin
          state_d = ACTIVE;
`ifdef UART_RX_CTRL_TIMEOUT_EN
          tcnt_d  = '0;
`endif
        end
`ifdef UART_RX_CTRL_TIMEOUT_EN
        else if (state_q == ACTIVE) begin
          if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
            state_d = ARMED;
            to_d    = 1'b1;
            tcnt_d  = '0;
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
`endif
      end
      HOLDOFF: begin
        if (hold_q == HW'(HOLDOFF_CYCLES - 1)) state_d = ARMED;
        else hold_d = hold_q + HW'(1);
      end
      default: state_d = IDLE;
    endcase
    // Disable wins over every other transition
    if (!ctrl_enable) begin
      state_d = IDLE;
      hold_d  = '0;
      to_d    = 1'b0;
`ifdef UART_RX_CTRL_TIMEOUT_EN
      tcnt_d  = '0;
`endif
    end
  end

  assign rx_en_d = (state_d == ARMED) || (state_d == ACTIVE);
  assign brk_d   = brk_req;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      hold_q  <= '0;
      rx_en_q <= 1'b0;
      brk_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      rx_en_q <= rx_en_d;
      brk_q   <= brk_d;
      to_q    <= to_d;
    end
  end

`ifdef UART_RX_CTRL_TIMEOUT_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) tcnt_q <= '0;
    else tcnt_q <= tcnt_d;
  end
`endif

  assign full = (level_q == LW'(FIFO_DEPTH));
  assign pop  = mval_q & m_ready;
  assign push = byte_req & (~full | pop);

  always_comb begin
    level_d = level_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    ovr_d   = ovr_q;
    if (ctrl_flush) begin
      level_d = '0;
      wptr_d  = '0;
      rptr_d  = '0;
      ovr_d   = 1'b0;
    end else begin
      if (push) wptr_d = wptr_q + AW'(1);
      if (pop) rptr_d = rptr_q + AW'(1);
      if (push && !pop) level_d = level_q + LW'(1);
      else if (pop && !push) level_d = level_q - LW'(1);
      if (byte_req && !push) ovr_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      ovr_q   <= 1'b0;
      mval_q  <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      ovr_q   <= ovr_d;
      mval_q  <= (level_d != '0);
      if (push && !ctrl_flush) mem_q[wptr_q] <= rx_data;
    end
  end

  assign rx_en      = rx_en_q;
  assign m_data     = mem_q[rptr_q];
  assign m_valid    = mval_q;
  assign fifo_level = level_q;
  assign overrun    = ovr_q;
  assign break_det  = brk_q;
  assign timeout    = to_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed and randomized checks of uart_rx_ctrl.
// Random phase is checked against a queue-based FIFO model.
module tb_uart_rx_ctrl;

  localparam int DEPTH = 8;
  localparam int HOLD  = 16;
  localparam int TOC   = 100;

  logic       clk;
  logic       resetn;
  logic       ctrl_enable;
  logic       ctrl_flush;
  logic       rx_en;
  logic       rx_valid;
  logic       rx_break;
  logic [7:0] rx_data;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic [3:0] fifo_level;
  logic       overrun;
  logic       break_det;
  logic       timeout;

  int total = 0;
  int bad   = 0;

  uart_rx_ctrl #(
    .PAYLOAD_BITS(8),
    .FIFO_DEPTH(DEPTH),
    .HOLDOFF_CYCLES(HOLD),
    .TIMEOUT_CYCLES(TOC)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .ctrl_enable(ctrl_enable),
    .ctrl_flush(ctrl_flush),
    .rx_en(rx_en),
    .rx_valid(rx_valid),
    .rx_break(rx_break),
    .rx_data(rx_data),
    .m_data(m_data),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .fifo_level(fifo_level),
    .overrun(overrun),
    .break_det(break_det),
    .timeout(timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic flush();
    ctrl_flush = 1'b1;
    tick();
    ctrl_flush = 1'b0;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_rx_en"}, 32'(rx_en), 0);
    chk({tag, "_m_valid"}, 32'(m_valid), 0);
    chk({tag, "_m_data"}, 32'(m_data), 0);
    chk({tag, "_level"}, 32'(fifo_level), 0);
    chk({tag, "_overrun"}, 32'(overrun), 0);
    chk({tag, "_break"}, 32'(break_det), 0);
    chk({tag, "_timeout"}, 32'(timeout), 0);
  endtask

  logic [7:0] q[$];
  logic       ov;
  logic       pop_m;
  logic       acc;

  initial begin
    resetn      = 1'b0;
    ctrl_enable = 1'b0;
    ctrl_flush  = 1'b0;
    rx_valid    = 1'b0;
    rx_break    = 1'b0;
    rx_data     = 8'h00;
    m_ready     = 1'b0;
    tick();
    tick();
    chk_reset_outs("rst");

    resetn = 1'b1;
    tick();
    chk("idle_rx_en", 32'(rx_en), 0);
    ctrl_enable = 1'b1;
    tick();
    chk("en_rise", 32'(rx_en), 1);

    send(8'h55);
    send(8'hA3);
    send(8'h0F);
    chk("t1_level", 32'(fifo_level), 3);
    chk("t1_head", 32'(m_data), 32'h55);
    chk("t1_valid", 32'(m_valid), 1);
    m_ready = 1'b1;
    chk("t1_d0", 32'(m_data), 32'h55);
    tick();
    chk("t1_d1", 32'(m_data), 32'hA3);
    tick();
    chk("t1_d2", 32'(m_data), 32'h0F);
    tick();
    chk("t1_empty", 32'(m_valid), 0);
    chk("t1_lvl0", 32'(fifo_level), 0);
    m_ready = 1'b0;

    for (int i = 1; i <= 9; i++) send(8'(i));
    chk("t2_level", 32'(fifo_level), 8);
    chk("t2_ovr", 32'(overrun), 1);
    m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk("t2_drain", 32'(m_data), 32'(i));
      tick();
    end
    m_ready = 1'b0;
    chk("t2_empty", 32'(m_valid), 0);
    chk("t2_ovr_sticky", 32'(overrun), 1);
    send(8'h31);
    send(8'h32);
    chk("t2_pre_flush", 32'(fifo_level), 2);
    rx_valid = 1'b1;
    rx_data  = 8'h33;
    flush();
    rx_valid = 1'b0;
    chk("t2_flush_lvl", 32'(fifo_level), 0);
    chk("t2_flush_ovr", 32'(overrun), 0);
    chk("t2_flush_val", 32'(m_valid), 0);
    tick();
    chk("t2_flush_lost", 32'(fifo_level), 0);

    for (int i = 0; i < 8; i++) send(8'(8'h10 + i));
    chk("t3_full", 32'(fifo_level), 8);
    rx_valid = 1'b1;
    rx_data  = 8'h77;
    m_ready  = 1'b1;
    tick();
    rx_valid = 1'b0;
    m_ready  = 1'b0;
    chk("t3_level", 32'(fifo_level), 8);
    chk("t3_ovr", 32'(overrun), 0);
    m_ready = 1'b1;
    for (int i = 1; i < 8; i++) begin
      chk("t3_drain", 32'(m_data), 32'(8'h10 + i));
      tick();
    end
    chk("t3_last", 32'(m_data), 32'h77);
    tick();
    m_ready = 1'b0;
    chk("t3_empty", 32'(m_valid), 0);

    rx_valid = 1'b1;
    rx_break = 1'b1;
    rx_data  = 8'hEE;
    tick();
    rx_valid = 1'b0;
    rx_break = 1'b0;
    chk("brk_det", 32'(break_det), 1);
    chk("brk_rx_en", 32'(rx_en), 0);
    chk("brk_not_stored", 32'(fifo_level), 0);
    for (int k = 2; k <= HOLD; k++) begin
      rx_valid = (k == 6);
      rx_data  = 8'h99;
      tick();
      chk("hold_rx_en", 32'(rx_en), 0);
    end
    rx_valid = 1'b0;
    tick();
    chk("hold_done", 32'(rx_en), 1);
    chk("hold_lvl", 32'(fifo_level), 0);
    chk("brk_pulse", 32'(break_det), 0);

    send(8'hC3);
`ifdef UART_RX_CTRL_TIMEOUT_EN
    for (int k = 1; k <= TOC; k++) begin
      chk("to_early", 32'(timeout), 0);
      tick();
    end
    chk("to_pulse", 32'(timeout), 1);
    tick();
    for (int k = 0; k < 50; k++) begin
      chk("to_after", 32'(timeout), 0);
      tick();
    end
`else
    for (int k = 0; k < 1000; k++) begin
      chk("to_none", 32'(timeout), 0);
      tick();
    end
`endif
    chk("to_byte", 32'(m_data), 32'hC3);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    chk("to_drained", 32'(m_valid), 0);

    flush();
    q.delete();
    ov = 1'b0;
    for (int i = 0; i < 400; i++) begin
      chk("rnd_level", 32'(fifo_level), 32'(q.size()));
      chk("rnd_valid", 32'(m_valid), 32'(q.size() != 0));
      chk("rnd_ovr", 32'(overrun), 32'(ov));
      if (q.size() != 0) chk("rnd_data", 32'(m_data), 32'(q[0]));
      rx_valid   = ($urandom_range(0, 1) == 0);
      rx_data    = 8'($urandom);
      m_ready    = ($urandom_range(0, 2) == 0);
      ctrl_flush = ($urandom_range(0, 39) == 0);
      if (ctrl_flush) begin
        q.delete();
        ov = 1'b0;
      end else begin
        pop_m = (q.size() != 0) && m_ready;
        acc   = rx_valid && ((q.size() < DEPTH) || pop_m);
        if (rx_valid && !acc) ov = 1'b1;
        if (pop_m) void'(q.pop_front());
        if (acc) q.push_back(rx_data);
      end
      tick();
    end
    rx_valid   = 1'b0;
    m_ready    = 1'b0;
    ctrl_flush = 1'b0;

    flush();
    send(8'hA1);
    send(8'hB2);
    ctrl_enable = 1'b0;
    tick();
    chk("dis_rx_en", 32'(rx_en), 0);
    chk("dis_level", 32'(fifo_level), 2);
    chk("dis_head", 32'(m_data), 32'hA1);
    send(8'h5A);
    chk("dis_ignored", 32'(fifo_level), 2);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    chk("dis_drain", 32'(m_data), 32'hB2);
    chk("dis_lvl1", 32'(fifo_level), 1);
    resetn = 1'b0;
    #1;
    chk_reset_outs("arst");
    tick();
    chk_reset_outs("arst2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
